// File: rtl/trdb_packet_receiver.sv
// Trace-debugger packet-word sink: collects 32-bit words into length-delimited packets.
// Optional TRDB_RX_STALL_EN gates grant_o with a 16-bit LFSR for pseudo-random backpressure.
module trdb_packet_receiver #(
  parameter int unsigned WordLen      = 32,
  parameter int unsigned LenBits      = 7,
  parameter int unsigned PacketMaxLen = 128,
  parameter int unsigned CntLen       = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [WordLen-1:0]      packet_word_i,
  input  logic                    packet_word_valid_i,
  output logic                    grant_o,
  output logic [PacketMaxLen-1:0] packet_o,
  output logic [LenBits-1:0]      packet_len_o,
  output logic                    packet_valid_o,
  input  logic                    packet_ready_i,
  output logic                    len_err_o,
  output logic [CntLen-1:0]       packet_cnt_o
);

  localparam int unsigned NumSlots  = PacketMaxLen / WordLen;
  localparam int unsigned SlotW     = $clog2(NumSlots + 1);
  localparam int unsigned WordShift = $clog2(WordLen);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_e;

  state_e                  state_q, state_d;
  logic [PacketMaxLen-1:0] packet_q, packet_d;
  logic [LenBits-1:0]      len_q, len_d;
  logic [SlotW-1:0]        cnt_q, cnt_d;
  logic [SlotW-1:0]        nwords_q, nwords_d;
  logic [CntLen-1:0]       pcnt_q, pcnt_d;
  logic                    grant_q, grant_d;
  logic                    len_err_q, len_err_d;
  logic                    stall_ok;

  logic                    xfer;
  logic [LenBits-1:0]      hdr_len;
  logic [SlotW-1:0]        hdr_nwords;
  logic [LenBits-1:0]      act_len;
  logic [SlotW-1:0]        act_slot;
  logic [PacketMaxLen-1:0] wr_vec;
  logic [PacketMaxLen-1:0] store_vec;

  function automatic logic [SlotW-1:0] words_for(input logic [LenBits-1:0] l);
    int unsigned n;
    n = (32'(l) + WordLen - 1) >> WordShift;
    return SlotW'(n);
  endfunction

  // Bits at or above the packet length never reach packet_o.
  function automatic logic [PacketMaxLen-1:0] len_mask(input logic [LenBits-1:0] l);
    logic [PacketMaxLen-1:0] m;
    for (int unsigned i = 0; i < PacketMaxLen; i++) m[i] = (i < 32'(l));
    return m;
  endfunction

  assign xfer       = packet_word_valid_i & grant_q;
  assign hdr_len    = packet_word_i[LenBits-1:0];
  assign hdr_nwords = words_for(hdr_len);
  assign act_len    = (state_q == IDLE) ? hdr_len : len_q;
  assign act_slot   = (state_q == IDLE) ? '0 : cnt_q;

  always_comb begin
    wr_vec = '0;
    for (int unsigned s = 0; s < NumSlots; s++)
      if (SlotW'(s) == act_slot) wr_vec[s*WordLen +: WordLen] = packet_word_i;
  end

  assign store_vec = wr_vec & len_mask(act_len);

`ifdef TRDB_RX_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign stall_ok = lfsr_d[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= 16'hACE1;
    else         lfsr_q <= lfsr_d;
  end
`else
  assign stall_ok = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (xfer && hdr_len != '0)
          state_d = (hdr_nwords == SlotW'(1)) ? DONE : COLLECT;
      end
      COLLECT: begin
        if (xfer && (cnt_q + SlotW'(1)) == nwords_q) state_d = DONE;
      end
      DONE: begin
        if (packet_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant is registered from the next state so it never depends on the incoming valid.
  always_comb begin
    grant_d        = (state_d != DONE) & stall_ok;
    packet_valid_o = (state_q == DONE);
  end

  always_comb begin
    packet_d  = packet_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    nwords_d  = nwords_q;
    pcnt_d    = pcnt_q;
    len_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          if (hdr_len == '0) begin
            len_err_d = 1'b1;
          end else begin
            len_d    = hdr_len;
            nwords_d = hdr_nwords;
            packet_d = packet_q | store_vec;
            cnt_d    = SlotW'(1);
          end
        end
      end
      COLLECT: begin
        if (xfer) begin
          packet_d = packet_q | store_vec;
          cnt_d    = cnt_q + SlotW'(1);
        end
      end
      DONE: begin
        if (packet_ready_i) begin
          packet_d = '0;
          cnt_d    = '0;
          pcnt_d   = pcnt_q + CntLen'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      packet_q  <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      nwords_q  <= '0;
      pcnt_q    <= '0;
      grant_q   <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      packet_q  <= packet_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      nwords_q  <= nwords_d;
      pcnt_q    <= pcnt_d;
      grant_q   <= grant_d;
      len_err_q <= len_err_d;
    end
  end

  assign grant_o      = grant_q;
  assign packet_o     = packet_q;
  assign packet_len_o = len_q;
  assign len_err_o    = len_err_q;
  assign packet_cnt_o = pcnt_q;

endmodule

// File: tb/tb_trdb_packet_receiver.sv
// Bench for trdb_packet_receiver: directed scenarios then random packets against a queue model.
module tb_trdb_packet_receiver;
  logic         gclk = 1'b0;
  logic         rst_n;
  logic [31:0]  word;
  logic         wvalid, grant, pvalid, ready, lerr;
  logic [127:0] pkt;
  logic [6:0]   plen;
  logic [15:0]  pcnt;

  int checks = 0, errors = 0;
  bit mon_en = 0, rnd_ready = 0;
  int err_seen = 0, exp_err = 0, exp_total = 0;
  logic [127:0] exp_pkt_q[$];
  logic [6:0]   exp_len_q[$];

  always #5 gclk = ~gclk;

  trdb_packet_receiver dut (
    .clk_i(gclk), .rst_ni(rst_n), .packet_word_i(word), .packet_word_valid_i(wvalid),
    .grant_o(grant), .packet_o(pkt), .packet_len_o(plen), .packet_valid_o(pvalid),
    .packet_ready_i(ready), .len_err_o(lerr), .packet_cnt_o(pcnt));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge gclk); #1;
    if (rnd_ready) ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_word(input logic [31:0] w);
    bit ok, x;
    ok = 0;
    wvalid = 1'b1; word = w;
    for (int b = 0; b < 300; b++) begin
      @(negedge gclk);
      x = grant;
      cyc();
      if (x) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 0, 1);
    wvalid = 1'b0; word = $urandom;
  endtask

  // Scoreboard: a packet leaves whenever valid and ready are both high before an edge.
  always @(negedge gclk) begin
    if (mon_en) begin
      if (lerr) err_seen++;
      if (pvalid) chk("grant_in_done", grant, 0);
      if (pvalid && ready) begin
        if (exp_pkt_q.size() == 0) chk("unexpected_pkt", 1, 0);
        else begin
          chk("rnd_pkt", pkt, exp_pkt_q.pop_front());
          chk("rnd_len", plen, exp_len_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [127:0] exp, acc;
    logic [31:0]  w;
    int len, nw;
    rst_n = 1'b0; wvalid = 1'b0; ready = 1'b0; word = '0;
    #12;
    chk("rst_grant", grant, 0);
    chk("rst_pkt", pkt, 0);
    chk("rst_len", plen, 0);
    chk("rst_valid", pvalid, 0);
    chk("rst_lerr", lerr, 0);
    chk("rst_cnt", pcnt, 0);
    @(negedge gclk); rst_n = 1'b1;

    // single word, len=20
    ready = 1'b1;
    send_word(32'h0000_0014);
    chk("t1_valid", pvalid, 1);
    chk("t1_pkt", pkt, 128'h14);
    chk("t1_len", plen, 20);
    cyc();
    chk("t1_cnt", pcnt, 1);
    chk("t1_valid_off", pvalid, 0);

    // three-word len=70 then hold ready low with next header pending
    ready = 1'b0;
    send_word(32'hA5A5_A546);
    send_word(32'h1234_5678);
    chk("t2_not_yet", pvalid, 0);
    send_word(32'hFFFF_FFFF);
    exp = 128'h3F_1234_5678_A5A5_A546;
    chk("t2_valid", pvalid, 1);
    chk("t2_pkt", pkt, exp);
    chk("t2_len", plen, 70);
    wvalid = 1'b1; word = 32'h0000_0020;
    for (int i = 0; i < 10; i++) begin
      @(negedge gclk);
      chk("t2_hold_grant", grant, 0);
      chk("t2_hold_pkt", pkt, exp);
    end
    @(posedge gclk); #1; ready = 1'b1;
    @(posedge gclk); #1;
    chk("t2_consumed", pvalid, 0);
    chk("t2_cnt", pcnt, 2);
    chk("t2_grant_back", grant, 1);
    @(posedge gclk); #1;
    wvalid = 1'b0;
    chk("t2_next_valid", pvalid, 1);
    chk("t2_next_pkt", pkt, 128'h20);
    chk("t2_next_len", plen, 32);
    @(posedge gclk); #1;
    chk("t2_next_cnt", pcnt, 3);

    // zero-length header
    send_word(32'hDEAD_BE80);
    chk("t3_lerr", lerr, 1);
    chk("t3_novalid", pvalid, 0);
    cyc();
    chk("t3_lerr_pulse", lerr, 0);
    send_word(32'h0000_0120);
    chk("t3_pkt", pkt, 128'h120);
    chk("t3_len", plen, 32);
    cyc();
    chk("t3_cnt", pcnt, 4);

    // reset mid-packet
    ready = 1'b0;
    send_word(32'h0000_0064);
    send_word(32'h1111_1111);
    rst_n = 1'b0; #1;
    chk("t4_rst_valid", pvalid, 0);
    chk("t4_rst_pkt", pkt, 0);
    chk("t4_rst_cnt", pcnt, 0);
    chk("t4_rst_len", plen, 0);
    chk("t4_rst_grant", grant, 0);
    @(negedge gclk); rst_n = 1'b1; ready = 1'b1;
    send_word(32'h0000_0A15);
    chk("t4_pkt", pkt, 128'hA15);
    chk("t4_len", plen, 21);
    cyc();
    chk("t4_cnt", pcnt, 1);

    // random packets
    exp_total = 1;
    mon_en = 1; rnd_ready = 1;
    for (int p = 0; p < 400; p++) begin
      len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 127);
      wvalid = 1'b0;
      repeat ($urandom_range(0, 2)) cyc();
      w = $urandom;
      w[6:0] = 7'(len);
      if (len == 0) begin
        exp_err++;
        send_word(w);
      end else begin
        nw = (len + 31) / 32;
        acc = 128'(w);
        for (int k = 1; k < nw; k++) acc = acc | (128'($urandom) << (32 * k));
        exp_pkt_q.push_back(acc & ((128'd1 << len) - 128'd1));
        exp_len_q.push_back(7'(len));
        exp_total++;
        send_word(w);
        for (int k = 1; k < nw; k++) begin
          repeat ($urandom_range(0, 2)) cyc();
          send_word(acc[32*k +: 32]);
        end
      end
    end
    rnd_ready = 0; ready = 1'b1;
    for (int b = 0; b < 100; b++) begin
      @(posedge gclk); #1;
      if (exp_pkt_q.size() == 0 && !pvalid) break;
    end
    mon_en = 0;
    chk("rnd_drained", 32'(exp_pkt_q.size()), 0);
    chk("rnd_cnt", pcnt, 16'(exp_total));
    chk("rnd_lerr_count", 32'(err_seen), 32'(exp_err));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
